regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Architectural GPR file that consumes the WB-stage write port (waddr/we/wdata) from the MEM/WB pipeline register.
//  It serves two combinational read ports to the ID stage, with same-cycle WB-to-ID bypass.
//  A per-register scoreboard counts in-flight writes issued from ID and not yet retired at WB.
//  ID reads of a register with a write still in flight raise stallreq_o, which goes to the stall controller.
// PARAMETERS
//  NREG    32  number of GPRs; index 0 reads as zero and is never written
//  DW      32  data width
//  AW      5   register address width, log2(NREG)
//  CNTW    2   scoreboard counter width per register; max 2**CNTW-1 outstanding writes
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     asynchronous active-low reset (0 = reset)
//  wb_we_i        in   1     WB write enable
//  wb_waddr_i     in   AW    WB destination register
//  wb_wdata_i     in   DW    WB write data
//  issue_i        in   1     ID issues an instruction this cycle (already qualified by stall)
//  issue_we_i     in   1     issued instruction writes a GPR
//  issue_waddr_i  in   AW    issued instruction destination
//  flush_i        in   1     pipeline flush; all in-flight writes are discarded
//  re1_i          in   1     read port 1 enable
//  raddr1_i       in   AW    read port 1 address
//  rdata1_o       out  DW    read port 1 data
//  re2_i          in   1     read port 2 enable
//  raddr2_i       in   AW    read port 2 address
//  rdata2_o       out  DW    read port 2 data
//  stallreq_o     out  1     ID hazard stall request
//  sb_ovf_o       out  1     sticky flag: a scoreboard counter saturated
// BEHAVIOUR
//  Reset (rst=0, async): all GPRs=0; all counters=0; sb_ovf_o=0.
//   Outputs are combinational: rdata*=0 and stallreq_o=0 while in reset.
//  Write: on posedge, if wb_we_i && wb_waddr_i!=0, then gpr[wb_waddr_i]<=wb_wdata_i. Writes to r0 are ignored.
//  Read (comb, 0 latency):
//   - re=0 or addr=0: data=0.
//   - else if wb_we_i && wb_waddr_i==addr: data=wb_wdata_i (bypass).
//   - else: data=gpr[addr].
//  Scoreboard per reg r!=0, updated on posedge:
//   - inc = issue_i && issue_we_i && issue_waddr_i==r.
//   - dec = wb_we_i && wb_waddr_i==r && cnt[r]!=0.
//   - inc&&dec: count unchanged. inc only: +1. dec only: -1.
//   - inc at max: count holds at max and sb_ovf_o<=1.
//   - dec at 0: no change; this is a retire without a matching issue and is legal.
//   - cnt[0] is held at 0.
//  flush_i=1: on that posedge all counters<=0, overriding inc/dec. The GPR write in the same cycle still happens.
//  stallreq_o=1 iff, for either port p, all of the following hold:
//   - re_p=1 and raddr_p!=0;
//   - cnt[raddr_p]!=0;
//   - NOT (cnt[raddr_p]==1 && wb_we_i && wb_waddr_i==raddr_p), i.e. the last outstanding write is not retiring this cycle.
//  stallreq_o does not depend on issue_i (there is no combinational loop through issue).
//  Both ports reading the same register is legal; both get the same data and the same hazard result.
//  sb_ovf_o is cleared only by reset.
// TESTING
//  1. Reset, then read r1..r31 on both ports -> all 0, stallreq_o=0.
//  2. WB write r5=0xDEADBEEF, read r5 in the same cycle -> rdata=0xDEADBEEF via bypass;
//     next cycle with wb_we_i=0 -> still 0xDEADBEEF from the array.
//  3. WB write r0=0x1234, read r0 -> 0; the r0 counter stays 0 after issue_waddr=0.
//  4. Issue r7 (cnt=1); next cycle read r7 -> stallreq_o=1.
//     Then WB r7=0x55 -> same cycle stallreq_o=0 and rdata=0x55; after that edge cnt=0.
//  5. Issue r3 twice (cnt=2), then WB r3 once -> stallreq_o stays 1; second WB r3 -> stallreq_o=0.
//     Issue r3 and WB r3 in the same cycle -> cnt unchanged.
//  6. Issue r9 four times with CNTW=2 -> cnt=3 and sb_ovf_o=1;
//     flush_i -> cnt=0, stallreq_o=0, sb_ovf_o stays 1;
//     async rst mid-cycle -> sb_ovf_o=0 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// Architectural GPR file with WB-to-ID bypass and a per-register in-flight write
// scoreboard that drives the ID hazard stall request.
module regfile_sb #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_waddr_i,
  input  logic [DW-1:0] wb_wdata_i,
  input  logic          issue_i,
  input  logic          issue_we_i,
  input  logic [AW-1:0] issue_waddr_i,
  input  logic          flush_i,
  input  logic          re1_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic          re2_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o,
  output logic          stallreq_o,
  output logic          sb_ovf_o
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [DW-1:0]   gpr [NREG];
  logic [CNTW-1:0] cnt [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;
  logic            sb_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register array is reset on purpose (architectural state must read zero), so it maps to flops, not RAM.
      for (int r = 0; r < NREG; r++) gpr[r] <= '0;
    end else if (wb_we_i && wb_waddr_i != '0) begin
      gpr[wb_waddr_i] <= wb_wdata_i;
    end
  end

  always_comb begin
    // NOTE: defaults first so every bit is assigned on every path and no latch is inferred.
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = issue_i && issue_we_i && (issue_waddr_i == AW'(r));
      dec_vec[r] = wb_we_i && (wb_waddr_i == AW'(r)) && (cnt[r] != '0);
    end
  end

  // Counter for r0 is only ever written by reset, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_ovf <= 1'b0;
    end else if (flush_i) begin
      for (int r = 1; r < NREG; r++) cnt[r] <= '0;
    end else begin
      // NOTE: non-blocking updates so each counter and the sticky flag change from pre-edge values only.
      for (int r = 1; r < NREG; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10: begin
            if (cnt[r] == CNT_MAX) sb_ovf <= 1'b1;
            else                   cnt[r] <= cnt[r] + CNT_ONE;
          end
          2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [DW-1:0] read_port(input logic re, input logic [AW-1:0] addr);
    if (!rst || !re || addr == '0)      return '0;
    if (wb_we_i && wb_waddr_i == addr)  return wb_wdata_i;
    return gpr[addr];
  endfunction

  // A hazard clears in the same cycle the last outstanding write retires at WB.
  function automatic logic hazard(input logic re, input logic [AW-1:0] addr);
    if (!rst || !re || addr == '0) return 1'b0;
    if (cnt[addr] == '0)           return 1'b0;
    return !(cnt[addr] == CNT_ONE && wb_we_i && wb_waddr_i == addr);
  endfunction

  always_comb begin
    rdata1_o   = read_port(re1_i, raddr1_i);
    rdata2_o   = read_port(re2_i, raddr2_i);
    stallreq_o = hazard(re1_i, raddr1_i) || hazard(re2_i, raddr2_i);
  end

  assign sb_ovf_o = sb_ovf;

endmodule
